// File: rtl/ospfb_fft_cfg_ctrl_if.sv
// ---------------------------------------------------------------
// ospfb_fft_cfg_ctrl_if : AXI4-Stream config channel (tdata/tvalid/tready)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface ospfb_fft_cfg_ctrl_if #(
  parameter int CONF_WID = 8
);
  logic [CONF_WID-1:0] tdata;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/ospfb_fft_cfg_ctrl.sv
// ---------------------------------------------------------------
// ospfb_fft_cfg_ctrl : OSPFB inverse-FFT config sequencer + status counters
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module ospfb_fft_cfg_ctrl #(
  parameter int FFT_LEN      = 128,
  parameter int SAMP_PER_CLK = 2,
  parameter int FFT_CONF_WID = 8,
  parameter int FFT_STAT_WID = 8,
  parameter int SCALE_WID    = FFT_CONF_WID - 1,
  parameter int DEF_FWD_INV  = 0,
  parameter int DEF_SCALE    = 0,
  parameter int BND_TIMEOUT  = 2 * FFT_LEN / SAMP_PER_CLK,
  parameter int FRM_CNT_WID  = 32,
  parameter int OVF_CNT_WID  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_update,
  input  logic                    cfg_fwd_inv,
  input  logic [SCALE_WID-1:0]    cfg_scale,
  ospfb_fft_cfg_ctrl_if.master    m_axis_config,
  input  logic                    fft_out_tvalid,
  input  logic                    fft_out_tready,
  input  logic                    fft_out_tlast,
  input  logic                    fft_status_tvalid,
  input  logic [FFT_STAT_WID-1:0] fft_status_tdata,
  input  logic                    ovf_clr,
  output logic                    active_fwd_inv,
  output logic [SCALE_WID-1:0]    active_scale,
  output logic                    cfg_busy,
  output logic                    cfg_applied,
  output logic [FRM_CNT_WID-1:0]  frame_cnt,
  output logic [OVF_CNT_WID-1:0]  ovf_cnt,
  output logic                    ovf_sticky
);

  localparam int TMR_W = $clog2(BND_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BND_TIMEOUT - 1);
  localparam logic [FFT_CONF_WID-1:0] DEF_WORD = {SCALE_WID'(DEF_SCALE), 1'(DEF_FWD_INV)};

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_BND = 2'd2,
    ST_SEND     = 2'd3
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [FFT_CONF_WID-1:0] r_shadow, w_shadow_nxt;
  logic                    r_pending, w_pending_nxt;
  logic [TMR_W-1:0]        r_timer, w_timer_nxt;
  logic [FFT_CONF_WID-1:0] w_tdata_nxt;
  logic                    w_hs;
  logic                    w_bnd;
  logic                    w_ovf;
  logic                    w_unused_stat;

  assign w_hs          = m_axis_config.tvalid & m_axis_config.tready;
  assign w_bnd         = fft_out_tvalid & fft_out_tready & fft_out_tlast;
  assign w_ovf         = fft_status_tvalid & fft_status_tdata[0];
  assign w_unused_stat = ^fft_status_tdata[FFT_STAT_WID-1:1];

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_timer_nxt   = r_timer;
    w_tdata_nxt   = m_axis_config.tdata;

    // Updates always land in the shadow; the in-flight word only changes on SEND entry.
    if (cfg_update) begin
      w_shadow_nxt  = {cfg_scale, cfg_fwd_inv};
      w_pending_nxt = 1'b1;
    end

    case (r_state)
      ST_INIT, ST_SEND: begin
        if (w_hs) begin
          w_state_nxt = w_pending_nxt ? ST_WAIT_BND : ST_RUN;
          w_timer_nxt = '0;
        end
      end
      ST_RUN: begin
        if (cfg_update) begin
          w_state_nxt = ST_WAIT_BND;
          w_timer_nxt = '0;
        end
      end
      ST_WAIT_BND: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        // A boundary seen in the entry cycle (timer still 0) is deliberately ignored.
        if ((w_bnd && (r_timer != '0)) || (r_timer == TMR_MAX)) begin
          w_state_nxt   = ST_SEND;
          w_tdata_nxt   = w_shadow_nxt;
          w_pending_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state              <= ST_INIT;
      r_shadow             <= '0;
      r_pending            <= 1'b0;
      r_timer              <= '0;
      m_axis_config.tvalid <= 1'b0;
      m_axis_config.tdata  <= DEF_WORD;
      active_fwd_inv       <= DEF_WORD[0];
      active_scale         <= DEF_WORD[FFT_CONF_WID-1:1];
      cfg_busy             <= 1'b1;
      cfg_applied          <= 1'b0;
      frame_cnt            <= '0;
      ovf_cnt              <= '0;
      ovf_sticky           <= 1'b0;
    end else begin
      r_state              <= w_state_nxt;
      r_shadow             <= w_shadow_nxt;
      r_pending            <= w_pending_nxt;
      r_timer              <= w_timer_nxt;
      m_axis_config.tvalid <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_SEND);
      m_axis_config.tdata  <= w_tdata_nxt;
      cfg_busy             <= (w_state_nxt != ST_RUN) || w_pending_nxt;
      cfg_applied          <= w_hs;
      if (w_hs) begin
        active_fwd_inv <= m_axis_config.tdata[0];
        active_scale   <= m_axis_config.tdata[FFT_CONF_WID-1:1];
      end

      if (w_bnd) begin
        frame_cnt <= frame_cnt + FRM_CNT_WID'(1);
      end

      // Clear wins over history but not over an overflow in the same cycle.
      if (ovf_clr) begin
        ovf_cnt    <= w_ovf ? OVF_CNT_WID'(1) : '0;
        ovf_sticky <= w_ovf;
      end else if (w_ovf) begin
        if (ovf_cnt != '1) begin
          ovf_cnt <= ovf_cnt + OVF_CNT_WID'(1);
        end
        ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ospfb_fft_cfg_ctrl.sv
// ---------------------------------------------------------------
// tb_ospfb_fft_cfg_ctrl : directed bench with an event-level reference model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_ospfb_fft_cfg_ctrl;

  localparam int BND_TIMEOUT = 128;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_update, cfg_fwd_inv;
  logic [6:0] cfg_scale;
  logic       out_tvalid, out_tready, out_tlast;
  logic       stat_tvalid;
  logic [7:0] stat_tdata;
  logic       ovf_clr;
  logic       active_fwd_inv, cfg_busy, cfg_applied, ovf_sticky;
  logic [6:0] active_scale;
  logic [31:0] frame_cnt;
  logic [15:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  ospfb_fft_cfg_ctrl_if #(.CONF_WID(8)) cfg_if ();

  ospfb_fft_cfg_ctrl #(
    .FFT_LEN(128), .SAMP_PER_CLK(2), .FFT_CONF_WID(8), .FFT_STAT_WID(8),
    .DEF_FWD_INV(0), .DEF_SCALE(0), .BND_TIMEOUT(BND_TIMEOUT),
    .FRM_CNT_WID(32), .OVF_CNT_WID(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_update(cfg_update), .cfg_fwd_inv(cfg_fwd_inv), .cfg_scale(cfg_scale),
    .m_axis_config(cfg_if),
    .fft_out_tvalid(out_tvalid), .fft_out_tready(out_tready), .fft_out_tlast(out_tlast),
    .fft_status_tvalid(stat_tvalid), .fft_status_tdata(stat_tdata),
    .ovf_clr(ovf_clr),
    .active_fwd_inv(active_fwd_inv), .active_scale(active_scale),
    .cfg_busy(cfg_busy), .cfg_applied(cfg_applied),
    .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks requests, their age while waiting, and the word on offer.
  bit         m_started = 0;
  bit         m_booting, m_offer, m_has_req, m_waiting, m_applied, m_sticky;
  logic [7:0] m_word, m_req, m_active;
  int         m_age, m_ovf;
  longint     m_frames;

  always @(posedge clk) begin : model
    bit hs, bnd;
    if (!rstn) begin
      m_started = 1; m_booting = 1; m_offer = 0; m_word = 8'h00; m_req = 8'h00;
      m_has_req = 0; m_waiting = 0; m_age = 0; m_active = 8'h00; m_applied = 0;
      m_frames = 0; m_ovf = 0; m_sticky = 0;
    end else if (m_started) begin
      hs  = m_offer && cfg_if.tready;
      bnd = out_tvalid && out_tready && out_tlast;
      if (bnd) m_frames++;
      if (ovf_clr) begin m_ovf = 0; m_sticky = 0; end
      if (stat_tvalid && stat_tdata[0]) begin
        if (m_ovf < 65535) m_ovf++;
        m_sticky = 1;
      end
      m_applied = hs;
      if (hs) m_active = m_word;
      if (cfg_update) begin m_req = {cfg_scale, cfg_fwd_inv}; m_has_req = 1; end
      if (hs) begin
        m_offer = 0; m_booting = 0;
        if (m_has_req) begin m_waiting = 1; m_age = 0; end
      end else if (m_booting) begin
        m_offer = 1;
      end else if (m_waiting) begin
        if ((bnd && m_age > 0) || m_age == BND_TIMEOUT - 1) begin
          m_word = m_req; m_has_req = 0; m_waiting = 0; m_offer = 1;
        end else begin
          m_age++;
        end
      end else if (!m_offer && m_has_req) begin
        m_waiting = 1; m_age = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_started) begin
      chk("tvalid", cfg_if.tvalid, m_offer);
      chk("tdata", cfg_if.tdata, m_word);
      chk("cfg_applied", cfg_applied, m_applied);
      chk("active_fwd_inv", active_fwd_inv, m_active[0]);
      chk("active_scale", active_scale, m_active[7:1]);
      chk("cfg_busy", cfg_busy, m_booting | m_offer | m_has_req | m_waiting);
      chk("frame_cnt", frame_cnt, m_frames[31:0]);
      chk("ovf_cnt", ovf_cnt, m_ovf[15:0]);
      chk("ovf_sticky", ovf_sticky, m_sticky);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_update(input bit f, input logic [6:0] s);
    cfg_update = 1; cfg_fwd_inv = f; cfg_scale = s;
    tick();
    cfg_update = 0;
  endtask

  task automatic pulse_bnd();
    out_tvalid = 1; out_tready = 1; out_tlast = 1;
    tick();
    out_tvalid = 0; out_tlast = 0;
  endtask

  initial begin
    int cnt;
    rstn = 0; cfg_update = 0; cfg_fwd_inv = 0; cfg_scale = '0;
    out_tvalid = 0; out_tready = 0; out_tlast = 0;
    stat_tvalid = 0; stat_tdata = '0; ovf_clr = 0;
    cfg_if.tready = 1;
    tick(3);

    // Reset release with tready high: one-cycle default word
    chk("rst_busy", cfg_busy, 1);
    rstn = 1;
    tick();
    chk("init_tvalid", cfg_if.tvalid, 1);
    chk("init_tdata", cfg_if.tdata, 8'h00);
    tick();
    chk("init_tvalid_drop", cfg_if.tvalid, 0);
    chk("init_applied", cfg_applied, 1);
    chk("init_busy_fall", cfg_busy, 0);
    tick();

    // INIT held with tready low
    rstn = 0; cfg_if.tready = 0;
    tick(2);
    rstn = 1;
    tick(21);
    chk("init_hold_tvalid", cfg_if.tvalid, 1);
    cfg_if.tready = 1;
    tick();
    chk("init_hold_applied", cfg_applied, 1);
    tick();

    // Update in RUN, boundary 10 cycles later
    pulse_update(1, 7'h2A);
    tick(9);
    pulse_bnd();
    chk("bnd_tvalid", cfg_if.tvalid, 1);
    chk("bnd_tdata", cfg_if.tdata, 8'h55);
    tick();
    chk("bnd_active_scale", active_scale, 7'h2A);
    chk("bnd_active_fwd", active_fwd_inv, 1);
    tick();

    // Timeout with no output traffic
    pulse_update(0, 7'h05);
    cnt = 0;
    while (cfg_if.tvalid !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("timeout_cycles", cnt, 128);
    tick(2);

    // Two updates in WAIT_BND, then one during SEND
    cfg_if.tready = 0;
    pulse_update(0, 7'h11);
    tick(2);
    pulse_update(0, 7'h22);
    tick(3);
    pulse_bnd();
    chk("last_wins_tdata", cfg_if.tdata, 8'h44);
    pulse_update(1, 7'h33);
    chk("inflight_tdata", cfg_if.tdata, 8'h44);
    cfg_if.tready = 1;
    tick();
    chk("first_apply_scale", active_scale, 7'h22);
    tick(2);
    pulse_bnd();
    chk("second_tvalid", cfg_if.tvalid, 1);
    chk("second_tdata", cfg_if.tdata, 8'h67);
    tick();
    chk("second_apply_scale", active_scale, 7'h33);
    chk("frame_count", frame_cnt, 32'd3);
    tick();

    // Overflow saturation, clear, clear+overflow
    stat_tvalid = 1; stat_tdata = 8'h01;
    tick(65540);
    stat_tvalid = 0;
    chk("ovf_saturate", ovf_cnt, 16'hFFFF);
    chk("ovf_sticky_set", ovf_sticky, 1);
    stat_tvalid = 1; stat_tdata = 8'hFE;
    tick();
    stat_tvalid = 0;
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr_cnt", ovf_cnt, 16'h0000);
    chk("ovf_clr_sticky", ovf_sticky, 0);
    ovf_clr = 1; stat_tvalid = 1; stat_tdata = 8'h01;
    tick();
    ovf_clr = 0; stat_tvalid = 0;
    chk("ovf_clr_coincident", ovf_cnt, 16'h0001);
    chk("ovf_clr_coinc_sticky", ovf_sticky, 1);

    // Reset in the middle of SEND
    cfg_if.tready = 0;
    pulse_update(1, 7'h7F);
    tick();
    pulse_bnd();
    chk("send_tdata", cfg_if.tdata, 8'hFF);
    rstn = 0;
    tick();
    chk("rst_send_tvalid", cfg_if.tvalid, 0);
    chk("rst_active_scale", active_scale, 7'h00);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    tick();
    rstn = 1;
    tick();
    chk("restart_tvalid", cfg_if.tvalid, 1);
    chk("restart_tdata", cfg_if.tdata, 8'h00);
    cfg_if.tready = 1;
    tick();
    chk("restart_applied", cfg_applied, 1);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ospfb_fft_cfg_ctrl.md
Name: ospfb_fft_cfg_ctrl

Overview:
Sequences the AXI4-Stream configuration channel of the OSPFB inverse FFT core. After reset it issues the default config word. Runtime updates to direction and scale schedule are applied only at an output frame boundary, or after a timeout if the FFT is idle. It also monitors the FFT status channel and keeps saturating overflow and frame counters for the register interface.

Parameters:
FFT_LEN, 128, polyphase branches (M); sets the default timeout
SAMP_PER_CLK, 2, samples per clock
FFT_CONF_WID, 8, config tdata width
FFT_STAT_WID, 8, status tdata width; bit 0 = overflow
SCALE_WID, FFT_CONF_WID-1, scale-schedule field width
DEF_FWD_INV, 0, reset direction (0 = inverse, 1 = forward)
DEF_SCALE, 0, reset scale schedule
BND_TIMEOUT, 2*FFT_LEN/SAMP_PER_CLK, max cycles to wait for a boundary (>=2)
FRM_CNT_WID, 32, frame counter width
OVF_CNT_WID, 16, overflow counter width

Ports:
clk  in  1  single clock
rstn  in  1  synchronous reset, active low
cfg_update  in  1  one-cycle pulse requesting a config update
cfg_fwd_inv  in  1  requested direction, sampled on cfg_update
cfg_scale  in  SCALE_WID  requested scale schedule, sampled on cfg_update
m_axis_config_tdata  out  FFT_CONF_WID  {scale, fwd_inv}; fwd_inv is bit 0
m_axis_config_tvalid  out  1  config valid
m_axis_config_tready  in  1  FFT accepts config
fft_out_tvalid  in  1  FFT data-output valid (monitor only)
fft_out_tready  in  1  downstream ready (monitor only)
fft_out_tlast  in  1  last beat of an output frame
fft_status_tvalid  in  1  status beat valid
fft_status_tdata  in  FFT_STAT_WID  status; bit 0 = overflow
ovf_clr  in  1  clears the overflow counter and sticky flag
active_fwd_inv  out  1  last accepted direction
active_scale  out  SCALE_WID  last accepted scale
cfg_busy  out  1  INIT, SEND, or update pending
cfg_applied  out  1  one-cycle pulse on config handshake
frame_cnt  out  FRM_CNT_WID  completed output frames, wraps
ovf_cnt  out  OVF_CNT_WID  overflow events, saturates at all-ones
ovf_sticky  out  1  set on any overflow

Behaviour:
- Boundary event: fft_out_tvalid & fft_out_tready & fft_out_tlast. Handshake: m_axis_config_tvalid & m_axis_config_tready.
- Reset (rstn low at clk edge, at any time, including mid-SEND):
  - state <= INIT; shadow and pending cleared.
  - tvalid 0 while rstn low; tdata = {DEF_SCALE, DEF_FWD_INV}.
  - active_* = DEF_*; frame_cnt, ovf_cnt, ovf_sticky, cfg_applied all 0; cfg_busy 1.
- States:
  - INIT: tvalid=1 from the first cycle after rstn goes high, with the default word. Handshake -> RUN. active_* unchanged (already default).
  - RUN: tvalid=0. cfg_update -> latch shadow, pending=1, timer=0 -> WAIT_BND.
  - WAIT_BND: timer increments each cycle. Boundary event OR timer==BND_TIMEOUT-1 -> SEND, tdata loaded from shadow. A boundary in the entry cycle is not counted; the earliest transition is one cycle after entry.
  - SEND: tvalid=1; tdata held stable until handshake. Handshake -> active_* <= word fields, cfg_applied=1 for one cycle, pending=0. Next state is WAIT_BND (timer=0) if a new update arrived during SEND, else RUN.
- cfg_update rules:
  - In WAIT_BND: overwrites shadow (last wins); timer not restarted.
  - In SEND: stored to shadow and pending, never alters the in-flight tdata.
  - In INIT: stored; after the INIT handshake goes to WAIT_BND.
- Latency: boundary event at cycle t -> tvalid high at t+1. Handshake at t -> active_* and cfg_applied at t+1.
- cfg_busy = (state != RUN) | pending.
- frame_cnt: +1 per boundary event, modulo 2^FRM_CNT_WID.
- Overflow: fft_status_tvalid & tdata[0] -> ovf_cnt +1 (saturating) and ovf_sticky=1.
  - ovf_clr zeroes both.
  - ovf_clr and an overflow in the same cycle -> ovf_cnt=1, ovf_sticky=1.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release with tready=1 -> tvalid high exactly 1 cycle, tdata=0x00, cfg_applied pulses, cfg_busy falls the next cycle.
- INIT with tready held 0 for 20 cycles -> tvalid held and tdata stable at 0x00 throughout; handshake on tready=1.
- cfg_update(fwd_inv=1, scale=0x2A) in RUN, boundary 10 cycles later -> tvalid at boundary+1, tdata=0x55, active_scale=0x2A after handshake.
- cfg_update with no output traffic, BND_TIMEOUT=128 -> SEND entered exactly 128 cycles after the update pulse.
- Two updates (0x11 then 0x22 scale) 3 cycles apart in WAIT_BND -> a single handshake with scale 0x22. An update during SEND -> a second config cycle follows.
- Overflow: 65540 overflow beats -> ovf_cnt=0xFFFF, sticky=1. ovf_clr coincident with an overflow -> ovf_cnt=1. rstn low mid-SEND -> tvalid 0 and INIT sequence restarts.
